// File: rtl/nonogram_pkg.sv
// Shared types and defaults for the nonogram line scheduler and solver.
// Holds the scheduler state encoding and the line-count/index-width defaults.
package nonogram_pkg;

    localparam int NUM_LINES = 32;
    localparam int IDX_W     = 5;
    localparam int PASS_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        DONE,
        STALL
    } sched_state_t;

endpackage

// File: rtl/line_index_queue.sv
// Circular queue of pending line indices with head/tail pointers and occupancy.
// Pointers wrap modulo DEPTH; clr_i empties the queue in one cycle.
module line_index_queue #(
    parameter int DEPTH = nonogram_pkg::NUM_LINES,
    parameter int IW    = nonogram_pkg::IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [IW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [IW-1:0] head_data_o,
    output logic [IW:0]   occ_o,
    output logic          empty_o
);

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [IW:0]   occ_q, occ_d;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clr_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push_i) tail_d = ptr_inc(tail_q);
            if (pop_i)  head_d = ptr_inc(head_q);
            occ_d = occ_q + (IW+1)'(push_i) - (IW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[tail_q] <= push_data_i;
    end

    assign head_data_o = mem_q[head_q];
    assign occ_o       = occ_q;
    assign empty_o     = (occ_q == '0);

endmodule

// File: rtl/nonogram_line_scheduler.sv
// Work-queue scheduler feeding line indices to the nonogram line solver.
// Define SCHED_PERF_EN to enable the saturating issued_cnt performance counter.
module nonogram_line_scheduler #(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = 5,
    parameter int PASS_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W:0]    num_lines,
    output logic              line_valid,
    input  logic              line_ready,
    output logic [IDX_W-1:0]  line_idx,
    input  logic              res_valid,
    input  logic              res_put_back,
    input  logic              res_progress,
    output logic              busy,
    output logic              done,
    output logic              stall,
    output logic [PASS_W-1:0] pass_cnt,
    output logic [15:0]       issued_cnt
);

    import nonogram_pkg::*;

    localparam int CW = IDX_W + 1;

    sched_state_t      state_q, state_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     load_k_q, load_k_d;
    logic [CW-1:0]     pass_left_q, pass_left_d;
    logic [CW-1:0]     noprog_q, noprog_d;
    logic [IDX_W-1:0]  held_q, held_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              vld_q, vld_d;
    logic [PASS_W-1:0] pass_q, pass_d;

    logic              start_ok, hs;
    logic              q_push, q_pop, q_empty;
    logic [IDX_W-1:0]  q_wdata, q_head, issue_idx;
    logic [CW-1:0]     q_occ, occ_after, n_clamp;

    assign start_ok  = start && (state_q inside {IDLE, DONE, STALL});
    assign hs        = vld_q && line_ready;
    assign n_clamp   = (num_lines > CW'(NUM_LINES)) ? CW'(NUM_LINES) : num_lines;
    assign q_pop     = (state_q == ISSUE) && hs;
    assign q_push    = (state_q == LOAD) ||
                       ((state_q == WAIT) && res_valid && res_put_back);
    assign q_wdata   = (state_q == LOAD) ? load_k_q[IDX_W-1:0] : held_q;
    assign occ_after = q_occ + CW'(res_put_back);
    // An empty queue means this cycle's push will become the head entry
    assign issue_idx = q_empty ? q_wdata : q_head;

    line_index_queue #(
        .DEPTH (NUM_LINES),
        .IW    (IDX_W)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (start_ok),
        .push_i      (q_push),
        .push_data_i (q_wdata),
        .pop_i       (q_pop),
        .head_data_o (q_head),
        .occ_o       (q_occ),
        .empty_o     (q_empty)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        load_k_d    = load_k_q;
        pass_left_d = pass_left_q;
        noprog_d    = noprog_q;
        held_d      = held_q;
        idx_d       = idx_q;
        vld_d       = vld_q;
        pass_d      = pass_q;
        unique case (state_q)
            IDLE, DONE, STALL: begin
                if (start_ok) begin
                    pass_d = '0;
                    if (n_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOAD;
                        n_d      = n_clamp;
                        load_k_d = '0;
                    end
                end
            end
            LOAD: begin
                load_k_d = load_k_q + 1'b1;
                if (load_k_d == n_q) begin
                    state_d     = ISSUE;
                    pass_left_d = n_q;
                    noprog_d    = '0;
                    vld_d       = 1'b1;
                    idx_d       = issue_idx;
                end
            end
            ISSUE: begin
                if (hs) begin
                    state_d = WAIT;
                    vld_d   = 1'b0;
                    held_d  = idx_q;
                end
            end
            WAIT: begin
                if (res_valid) begin
                    noprog_d    = res_progress ? '0 : noprog_q + 1'b1;
                    pass_left_d = pass_left_q - 1'b1;
                    if (pass_left_q == CW'(1)) begin
                        if (pass_q != '1) pass_d = pass_q + 1'b1;
                        pass_left_d = occ_after;
                    end
                    if (occ_after == '0) begin
                        state_d = DONE;
                    end else if (!res_progress &&
                                 ((noprog_q + 1'b1) >= occ_after)) begin
                        state_d = STALL;
                    end else begin
                        state_d = ISSUE;
                        vld_d   = 1'b1;
                        idx_d   = issue_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            load_k_q    <= '0;
            pass_left_q <= '0;
            noprog_q    <= '0;
            held_q      <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
            pass_q      <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            load_k_q    <= load_k_d;
            pass_left_q <= pass_left_d;
            noprog_q    <= noprog_d;
            held_q      <= held_d;
            idx_q       <= idx_d;
            vld_q       <= vld_d;
            pass_q      <= pass_d;
        end
    end

    assign line_valid = vld_q;
    assign line_idx   = idx_q;
    assign busy       = state_q inside {LOAD, ISSUE, WAIT};
    assign done       = (state_q == DONE);
    assign stall      = (state_q == STALL);
    assign pass_cnt   = pass_q;

`ifdef SCHED_PERF_EN
    logic [15:0] issued_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
        end else if (start_ok) begin
            issued_q <= '0;
        end else if (hs && (issued_q != 16'hFFFF)) begin
            issued_q <= issued_q + 1'b1;
        end
    end

    assign issued_cnt = issued_q;
`else
    assign issued_cnt = '0;
`endif

endmodule

// File: tb/tb_nonogram_line_scheduler.sv
// Scoreboard bench for nonogram_line_scheduler against a queue-level reference model.
// Issue order is checked by a monitor; run outcome is checked after each solve.
module tb_nonogram_line_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  num_lines = '0;
    logic        line_valid;
    logic        line_ready = 1'b0;
    logic [4:0]  line_idx;
    logic        res_valid = 1'b0;
    logic        res_put_back = 1'b0;
    logic        res_progress = 1'b0;
    logic        busy, done, stall;
    logic [7:0]  pass_cnt;
    logic [15:0] issued_cnt;

    int checks = 0;
    int failures = 0;

    int exp_q[$];
    bit pb_l[$];
    bit pr_l[$];
    int exp_pass;
    int exp_issues;
    bit exp_done, exp_stall;

    nonogram_line_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_lines    (num_lines),
        .line_valid   (line_valid),
        .line_ready   (line_ready),
        .line_idx     (line_idx),
        .res_valid    (res_valid),
        .res_put_back (res_put_back),
        .res_progress (res_progress),
        .busy         (busy),
        .done         (done),
        .stall        (stall),
        .pass_cnt     (pass_cnt),
        .issued_cnt   (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: sweep the pending list one snapshot at a time, recording
    // issue order and the solver answers handed out for each visit.
    function automatic void run_model(input int nreq, input int mode);
        int q[$];
        int n, noprog, visits;
        bit fin, pb, pr, seen1;
        n = (nreq > 32) ? 32 : nreq;
        exp_pass = 0; exp_done = 0; exp_stall = 0; exp_issues = 0;
        pb_l.delete(); pr_l.delete(); exp_q.delete();
        noprog = 0; visits = 0; fin = 0; seen1 = 0;
        if (n == 0) begin
            exp_done = 1;
            return;
        end
        for (int i = 0; i < n; i++) q.push_back(i);
        while (!fin) begin
            int sweep;
            sweep = q.size();
            for (int s = 0; s < sweep && !fin; s++) begin
                int idx;
                idx = q.pop_front();
                exp_q.push_back(idx);
                exp_issues++;
                case (mode)
                    1: begin pb = 0; pr = 1; end
                    2: begin pb = (idx == 1) && !seen1; pr = 1;
                             if (idx == 1) seen1 = 1; end
                    3: begin pb = 1; pr = (visits < 2); end
                    default: begin
                        pb = (visits < 50) && ($urandom_range(0, 2) == 0);
                        pr = ($urandom_range(0, 3) != 0);
                    end
                endcase
                visits++;
                pb_l.push_back(pb);
                pr_l.push_back(pr);
                if (pb) q.push_back(idx);
                noprog = pr ? 0 : noprog + 1;
                if (s == sweep - 1 && exp_pass < 255) exp_pass++;
                if (q.size() == 0) begin
                    exp_done = 1; fin = 1;
                end else if (!pr && noprog >= q.size()) begin
                    exp_stall = 1; fin = 1;
                end
            end
        end
    endfunction

    logic       pv = 1'b0;
    logic       prdy = 1'b0;
    logic [4:0] pidx = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv <= 1'b0;
        end else begin
            if (pv && !prdy)
                chk("hold_stable", {line_valid, line_idx}, {1'b1, pidx});
            if (line_valid && line_ready) begin
                chk("issue_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("issue_idx", line_idx, exp_q.pop_front());
            end
            pv   <= line_valid;
            prdy <= line_ready;
            pidx <= line_idx;
        end
    end

    task automatic do_run(input int nreq, input int mode, input int bp);
        int k, cyc, wcnt, hold;
        bit waiting, hs;
        k = 0; cyc = 0; wcnt = 0; hold = 0; waiting = 0; hs = 0;
        run_model(nreq, mode);
        @(posedge clk); #1;
        start = 1'b1;
        num_lines = nreq[5:0];
        @(posedge clk); #1;
        start = 1'b0;
        if (nreq == 0)
            chk("zero_done", {done, stall, busy}, 3'b100);
        else
            chk("start_busy", {busy, done, stall, pass_cnt}, 11'h400);
        chk("start_issued", issued_cnt, 0);
        while (!(done || stall) && cyc < 4000) begin
            res_valid = 1'b0;
            if (hs) begin
                waiting = 1;
                wcnt = $urandom_range(0, 2);
                hold = 0;
            end
            if (waiting) begin
                if (wcnt == 0) begin
                    res_valid    = 1'b1;
                    res_put_back = (k < pb_l.size()) ? pb_l[k] : 1'b0;
                    res_progress = (k < pr_l.size()) ? pr_l[k] : 1'b1;
                    k++;
                    waiting = 0;
                end else begin
                    wcnt--;
                end
            end else if (line_valid && $urandom_range(0, 3) == 0) begin
                res_valid    = 1'b1;
                res_put_back = 1'($urandom_range(0, 1));
                res_progress = 1'($urandom_range(0, 1));
            end
            if (line_valid) hold++;
            case (bp)
                0:       line_ready = 1'b1;
                1:       line_ready = 1'($urandom_range(0, 1));
                default: line_ready = (hold > 5);
            endcase
            hs = line_valid && line_ready;
            @(posedge clk); #1;
            cyc++;
        end
        res_valid = 1'b0;
        chk("run_timeout", cyc >= 4000, 0);
        chk("end_done", done, exp_done);
        chk("end_stall", stall, exp_stall);
        chk("end_pass_cnt", pass_cnt, exp_pass);
        chk("end_busy_valid", {busy, line_valid}, 2'b00);
        chk("results_used", k, pb_l.size());
        chk("issues_left", exp_q.size(), 0);
`ifdef SCHED_PERF_EN
        chk("issued_cnt", issued_cnt, exp_issues);
`else
        chk("issued_cnt", issued_cnt, 0);
`endif
        res_valid = 1'b1;
        res_put_back = 1'b1;
        res_progress = 1'b0;
        @(posedge clk); #1;
        res_valid = 1'b0;
        chk("idle_ignore_res", {done, stall, busy, pass_cnt},
            {exp_done, exp_stall, 1'b0, 8'(exp_pass)});
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {line_valid, line_idx, busy, done, stall, pass_cnt, issued_cnt}, 0);
        rst_n = 1'b1;

        do_run(4, 1, 0);
        do_run(3, 2, 0);
        do_run(2, 3, 0);
        do_run(0, 1, 0);
        do_run(5, 1, 2);
        do_run(40, 1, 1);

        exp_q.delete();
        exp_q.push_back(0);
        @(posedge clk); #1;
        start = 1'b1;
        num_lines = 6'd3;
        line_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!(line_valid && line_ready) && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rst_reach_issue", c >= 50, 0);
        @(posedge clk); #1;
        chk("rst_in_wait", {busy, line_valid}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rst_async",
            {line_valid, line_idx, busy, done, stall, pass_cnt, issued_cnt}, 0);
        res_valid = 1'b1;
        res_put_back = 1'b1;
        res_progress = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        chk("rst_stale_res", {busy, done, stall, line_valid, pass_cnt}, 0);
        do_run(1, 1, 0);

        for (int r = 0; r < 10; r++)
            do_run($urandom_range(1, 12), 0, $urandom_range(0, 2));
        do_run(20, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nonogram_line_scheduler.md
Name: nonogram_line_scheduler

Overview:
- Sequences row/column lines through the FIFO-based line solver.
- Holds a circular work queue of pending line indices. Issues one line at a time over a valid/ready handshake, then waits for the solver's verdict.
- Re-enqueues lines the solver puts back, retires lines it finishes, and reports done (queue empty) or stall (a full queue sweep with no new cell assignments; the board needs guessing).

Parameters:
- NUM_LINES, 32: maximum rows+cols handled; queue depth.
- IDX_W, 5: line index width, $clog2(NUM_LINES).
- PASS_W, 8: width of the pass counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a solve. Ignored unless state is IDLE, DONE or STALL.
- num_lines  in  IDX_W+1  lines in this puzzle. Sampled on accepted start; clamped to NUM_LINES.
- line_valid  out  1  line_idx is offered to the solver.
- line_ready  in  1  solver accepts the line.
- line_idx  out  IDX_W  index of the line being issued.
- res_valid  in  1  solver result strobe for the issued line.
- res_put_back  in  1  line still unresolved; requeue it.
- res_progress  in  1  solver assigned at least one new cell on this line.
- busy  out  1  state is LOAD, ISSUE or WAIT.
- done  out  1  all lines retired.
- stall  out  1  no-progress sweep detected.
- pass_cnt  out  PASS_W  completed sweeps, saturating.
- issued_cnt  out  16  lines issued; only with SCHED_PERF_EN, else tied 0.

Behaviour:
- Reset: state IDLE; head=tail=occ=0; all outputs 0.
- States:
  - IDLE→LOAD on start with num_lines>0.
  - IDLE/DONE/STALL→DONE on start with num_lines=0 (done=1 next cycle).
- LOAD:
  - Writes index k into slot k, one per cycle, k=0..N-1, where N is the clamped num_lines; tail and occ advance each cycle.
  - After the N-th write, goes to ISSUE. pass_left=N, noprog=0.
- ISSUE:
  - line_valid=1 and line_idx=queue[head], registered outputs.
  - On line_valid&line_ready: pop (head++ mod NUM_LINES, occ--), go to WAIT, deassert line_valid the next cycle.
  - line_idx holds stable while line_valid=1 and ready is low.
- WAIT:
  - res_valid ignored in every other state; line_valid=0.
  - On res_valid:
    - put_back=1: push the held index at tail (occ++).
    - progress=1: noprog:=0; else noprog:=noprog+1.
    - pass_left--; when it reaches 0: pass_cnt++ (saturating at all-ones), pass_left:=occ after push.
  - Next state, priority order:
    - occ_after=0 → DONE.
    - progress=0 and noprog+1 ≥ occ_after → STALL.
    - else → ISSUE.
- Simultaneous push and pop cannot occur: pop happens only in ISSUE, push only in WAIT. occ never exceeds N, so the queue never overflows. head/tail wrap modulo NUM_LINES.
- DONE: done=1, busy=0. STALL: stall=1, busy=0. Both hold until the next accepted start.
- On a new start, done, stall and pass_cnt clear on the start cycle.
- Minimum per-line latency is 2 cycles: handshake cycle, then result cycle.
- rst_n low mid-operation clears everything immediately. No stale res_valid is honoured afterwards.

Optional Feature:
- Macro SCHED_PERF_EN.
- Defined: issued_cnt increments on each line_valid&line_ready, saturates at 16'hFFFF, and clears on accepted start.
- Undefined: no counter logic; issued_cnt is driven constant 0. The port list is unchanged.

Decomposition:
- Shared package nonogram_pkg: sched_state_t enum (IDLE, LOAD, ISSUE, WAIT, DONE, STALL) and the NUM_LINES/IDX_W defaults, shared with the solver.
- One natural sub-module, line_index_queue: circular RAM plus head/tail/occ, with push, pop, occ and empty ports.
- The scheduler FSM and counters live in the top module.

Test Plan:
- Fast path, num_lines=4, ready always 1:
  - Results: put_back=0, progress=1 for all lines.
  - Expect issue order 0,1,2,3; done=1 after the 4th result; pass_cnt=1; stall=0.
- Requeue order, num_lines=3:
  - Line 1 returns put_back=1, progress=1 on its first visit; all others retire.
  - Expect issue order 0,1,2,1; then done; pass_cnt=2.
- Stall, num_lines=2:
  - First sweep: both lines put_back=1, progress=1.
  - Second sweep: both put_back=1, progress=0.
  - Expect stall=1 after the 4th result, done=0, busy=0.
- Backpressure:
  - Hold line_ready=0 for 5 cycles in ISSUE.
  - Expect line_valid=1 and line_idx stable throughout; one pop only.
  - A res_valid pulse during ISSUE is ignored (occ unchanged).
- num_lines=0 → done=1 one cycle after start. num_lines=40 → clamped to 32 lines loaded (indices 0..31).
- Reset mid-WAIT:
  - Drop rst_n during WAIT → all outputs 0 immediately.
  - A later start with num_lines=1 proceeds normally.
  - With SCHED_PERF_EN, issued_cnt restarts from 0.
